// File: rtl/sd_write_stream_dat.sv
// sd_write_stream_dat: card-to-host DAT[3:0] transmitter for the SDIO slave.
// Frames a block as predrive F, start 0, 2N data nibbles (high nibble first),
// a 16-bit CRC per DAT line (MSB first) and an end F nibble, then releases the
// bus. All DAT updates happen on detected falling edges of the oversampled
// sd_clock. Bytes come from an upstream buffer via a fixed-latency request.

// Serial CRC16 (x^16 + x^12 + x^5 + 1, init 0) for one DAT line.
module sd_crc16 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);
    logic [15:0] crc_r;

    // One LFSR step: shift left and fold in the polynomial when feedback is set.
    function automatic logic [15:0] crc16_step(input logic [15:0] cur, input logic b);
        logic fb;
        fb = b ^ cur[15];
        crc16_step = {cur[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Accumulate one bit per enabled cycle; clear at the start of each block.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_r <= 16'h0000;
        end else if (clear) begin
            crc_r <= 16'h0000;
        end else if (enable) begin
            crc_r <= crc16_step(crc_r, bit_in);
        end
    end

    assign crc = crc_r;
endmodule

module sd_write_stream_dat #(
    parameter int BYTE_LATENCY = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sd_clock,
    input  logic       write_strobe,
    input  logic [8:0] data_count,
    input  logic [7:0] byte_in,
    input  logic       abort,
    output logic       read_byte_strobe,
    output logic [3:0] sd_data_out,
    output logic       sd_data_oe,
    output logic       busy,
    output logic       write_all_strobe
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREDRIVE = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_CRC      = 3'd4,
        ST_END      = 3'd5,
        ST_RELEASE  = 3'd6
    } state_t;

    state_t                  state_r;
    logic                    sync1_r;
    logic                    sync2_r;
    logic                    sync3_r;
    logic                    fall_s;
    logic                    abort_now_s;
    // Holds 2N modulo 1024; 512 bytes load as 0 and the wrap yields 1024 nibbles.
    logic [9:0]              nib_cnt_r;
    logic [3:0]              crc_idx_r;
    logic [7:0]              byte_buf_r;
    logic [3:0]              low_nib_r;
    logic [BYTE_LATENCY-1:0] req_pipe_r;
    logic                    abort_pend_r;
    logic                    aborted_r;
    logic                    crc_clr_r;
    logic                    crc_en_r;
    logic [3:0]              crc_bits_r;
    logic [15:0]             crc_line_s [4];
    logic [3:0]              data_out_r;
    logic                    oe_r;
    logic                    busy_r;
    logic                    rbs_r;
    logic                    was_r;

    assign fall_s      = sync3_r & ~sync2_r;
    assign abort_now_s = abort_pend_r | abort;

    // Bring sd_clock into the clock domain and keep one extra stage for edge detect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= sd_clock;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Track outstanding byte requests and capture byte_in exactly BYTE_LATENCY cycles later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_pipe_r <= '0;
            byte_buf_r <= 8'h00;
        end else begin
            req_pipe_r <= BYTE_LATENCY'({req_pipe_r, rbs_r});
            if (req_pipe_r[BYTE_LATENCY-1]) begin
                byte_buf_r <= byte_in;
            end
        end
    end

    // One CRC generator per DAT line, each fed its own bit of every data nibble.
    for (genvar k = 0; k < 4; k++) begin : g_crc
        sd_crc16 u_crc (
            .clock   (clock),
            .reset_n (reset_n),
            .clear   (crc_clr_r),
            .enable  (crc_en_r),
            .bit_in  (crc_bits_r[k]),
            .crc     (crc_line_s[k])
        );
    end

    // Transfer sequencer: every bus change is taken on a detected sd_clock falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            nib_cnt_r    <= 10'd0;
            crc_idx_r    <= 4'd0;
            low_nib_r    <= 4'h0;
            abort_pend_r <= 1'b0;
            aborted_r    <= 1'b0;
            crc_clr_r    <= 1'b0;
            crc_en_r     <= 1'b0;
            crc_bits_r   <= 4'h0;
            data_out_r   <= 4'hF;
            oe_r         <= 1'b0;
            busy_r       <= 1'b0;
            rbs_r        <= 1'b0;
            was_r        <= 1'b0;
        end else begin
            rbs_r     <= 1'b0;
            was_r     <= 1'b0;
            crc_en_r  <= 1'b0;
            crc_clr_r <= 1'b0;
            if (abort && (state_r != ST_IDLE)) begin
                abort_pend_r <= 1'b1;
            end
            if (fall_s && abort_now_s &&
                (state_r inside {ST_PREDRIVE, ST_START, ST_DATA, ST_CRC})) begin
                // Abort: take the end-nibble step right away, then release.
                data_out_r   <= 4'hF;
                aborted_r    <= 1'b1;
                abort_pend_r <= 1'b0;
                state_r      <= ST_RELEASE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        abort_pend_r <= 1'b0;
                        if (write_strobe) begin
                            nib_cnt_r <= {data_count, 1'b0};
                            crc_clr_r <= 1'b1;
                            busy_r    <= 1'b1;
                            aborted_r <= 1'b0;
                            state_r   <= ST_PREDRIVE;
                        end
                    end
                    ST_PREDRIVE: begin
                        if (fall_s) begin
                            oe_r       <= 1'b1;
                            data_out_r <= 4'hF;
                            rbs_r      <= 1'b1;
                            state_r    <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (fall_s) begin
                            data_out_r <= 4'h0;
                            state_r    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (fall_s) begin
                            crc_en_r <= 1'b1;
                            if (!nib_cnt_r[0]) begin
                                // High nibble; keep the low half since the buffer refills next.
                                data_out_r <= byte_buf_r[7:4];
                                crc_bits_r <= byte_buf_r[7:4];
                                low_nib_r  <= byte_buf_r[3:0];
                                if (nib_cnt_r != 10'd2) begin
                                    rbs_r <= 1'b1;
                                end
                            end else begin
                                data_out_r <= low_nib_r;
                                crc_bits_r <= low_nib_r;
                            end
                            nib_cnt_r <= nib_cnt_r - 10'd1;
                            if (nib_cnt_r == 10'd1) begin
                                crc_idx_r <= 4'd15;
                                state_r   <= ST_CRC;
                            end
                        end
                    end
                    ST_CRC: begin
                        if (fall_s) begin
                            data_out_r <= {crc_line_s[3][crc_idx_r], crc_line_s[2][crc_idx_r],
                                           crc_line_s[1][crc_idx_r], crc_line_s[0][crc_idx_r]};
                            crc_idx_r  <= crc_idx_r - 4'd1;
                            if (crc_idx_r == 4'd0) begin
                                state_r <= ST_END;
                            end
                        end
                    end
                    ST_END: begin
                        if (fall_s) begin
                            data_out_r   <= 4'hF;
                            aborted_r    <= aborted_r | abort_now_s;
                            abort_pend_r <= 1'b0;
                            state_r      <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (fall_s) begin
                            oe_r         <= 1'b0;
                            was_r        <= ~(aborted_r | abort_now_s);
                            busy_r       <= 1'b0;
                            abort_pend_r <= 1'b0;
                            state_r      <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign read_byte_strobe = rbs_r;
    assign sd_data_out      = data_out_r;
    assign sd_data_oe       = oe_r;
    assign busy             = busy_r;
    assign write_all_strobe = was_r;
endmodule

// File: tb/tb_sd_write_stream_dat.sv
// Directed-plus-random bench for sd_write_stream_dat. Expected bus traffic is
// derived from the block contents: framing nibbles, data nibbles and CRC16
// remainders computed by polynomial long division per DAT line.
module tb_sd_write_stream_dat;
    localparam int LAT = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       sd_clock = 1'b0;
    logic       write_strobe = 1'b0;
    logic [8:0] data_count = 9'd0;
    logic [7:0] byte_in = 8'h00;
    logic       abort = 1'b0;
    logic       read_byte_strobe;
    logic [3:0] sd_data_out;
    logic       sd_data_oe;
    logic       busy;
    logic       write_all_strobe;

    logic       sd_run = 1'b0;
    logic [7:0] data_mem [0:511];
    logic [3:0] obs_q [$];
    logic [3:0] exp_q [$];
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    int         fail_cnt = 0;
    int         req_cnt = 0;
    int         req_base = 0;
    int         wa_cnt = 0;
    int         wa_bad = 0;
    int         obs_base = 0;
    int         wa_base = 0;
    int         wabad_base = 0;
    logic       oe_prev = 1'b0;

    sd_write_stream_dat #(.BYTE_LATENCY(LAT)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .sd_clock         (sd_clock),
        .write_strobe     (write_strobe),
        .data_count       (data_count),
        .byte_in          (byte_in),
        .abort            (abort),
        .read_byte_strobe (read_byte_strobe),
        .sd_data_out      (sd_data_out),
        .sd_data_oe       (sd_data_oe),
        .busy             (busy),
        .write_all_strobe (write_all_strobe)
    );

    always #5 clock = ~clock;

    // sd_clock at 1/16 of clock, gateable to emulate a stopped card clock.
    initial begin
        #2;
        forever begin
            #80;
            if (sd_run) sd_clock = ~sd_clock;
        end
    end

    // Upstream buffer: answer each request with the next byte of the block.
    always @(posedge clock) begin
        if (read_byte_strobe) begin
            byte_in <= data_mem[9'(req_cnt - req_base)];
            req_cnt <= req_cnt + 1;
        end
    end

    // Host side: sample DAT on rising sd_clock while driven.
    always @(posedge sd_clock) begin
        if (sd_data_oe) obs_q.push_back(sd_data_out);
    end

    // Count completion pulses and whether each lines up with oe falling.
    always @(negedge clock) begin
        if (write_all_strobe) begin
            wa_cnt <= wa_cnt + 1;
            if (!(oe_prev && !sd_data_oe)) wa_bad <= wa_bad + 1;
        end
        oe_prev <= sd_data_oe;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // CRC16 as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_ref(input int n, input int line);
        bit r [0:1039];
        int len;
        logic [15:0] res;
        len = 2 * n;
        for (int i = 0; i < 1040; i++) r[i] = 1'b0;
        for (int b = 0; b < n; b++) begin
            r[2*b]   = data_mem[b][4+line];
            r[2*b+1] = data_mem[b][line];
        end
        for (int i = 0; i < len; i++) begin
            if (r[i]) begin
                r[i]    = ~r[i];
                r[i+4]  = ~r[i+4];
                r[i+11] = ~r[i+11];
                r[i+16] = ~r[i+16];
            end
        end
        for (int j = 0; j < 16; j++) res[15-j] = r[len+j];
        return res;
    endfunction

    task automatic build_expected(input int n);
        logic [15:0] c [4];
        exp_q.delete();
        exp_q.push_back(4'hF);
        exp_q.push_back(4'h0);
        for (int b = 0; b < n; b++) begin
            exp_q.push_back(data_mem[b][7:4]);
            exp_q.push_back(data_mem[b][3:0]);
        end
        for (int k = 0; k < 4; k++) c[k] = crc_ref(n, k);
        for (int i = 15; i >= 0; i--) exp_q.push_back({c[3][i], c[2][i], c[1][i], c[0][i]});
        exp_q.push_back(4'hF);
    endtask

    task automatic start_xfer(input logic [8:0] cnt, input logic with_abort);
        @(negedge clock);
        obs_base   = obs_q.size();
        req_base   = req_cnt;
        wa_base    = wa_cnt;
        wabad_base = wa_bad;
        write_strobe = 1'b1;
        data_count   = cnt;
        abort        = with_abort;
        @(negedge clock);
        write_strobe = 1'b0;
        abort        = 1'b0;
        check("busy_on_start", busy, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        for (i = 0; i < budget && busy; i++) @(negedge clock);
        check({tag, "_idle_timeout"}, (i >= budget) ? 1 : 0, 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_obs(input string tag, input int cnt);
        int i;
        for (i = 0; i < 20000 && (obs_q.size() - obs_base) < cnt; i++) @(negedge clock);
        check({tag, "_obs_timeout"}, (i >= 20000) ? 1 : 0, 0);
    endtask

    task automatic check_seq(input string tag, input int exp_len);
        int first_bad;
        first_bad = -1;
        check({tag, "_len"}, obs_q.size() - obs_base, exp_len);
        for (int i = 0; i < exp_len && i < exp_q.size(); i++) begin
            if (first_bad < 0 && (obs_base + i >= obs_q.size() || obs_q[obs_base+i] !== exp_q[i]))
                first_bad = i;
        end
        check({tag, "_seq_first_diff"}, first_bad, -1);
    endtask

    task automatic verify_full(input string tag, input int n);
        build_expected(n);
        wait_idle(tag, 20000);
        check_seq(tag, 2*n + 19);
        check({tag, "_reqs"}, req_cnt - req_base, n);
        check({tag, "_done_pulses"}, wa_cnt - wa_base, 1);
        check({tag, "_done_align"}, wa_bad - wabad_base, 0);
        check({tag, "_oe_released"}, sd_data_oe, 0);
    endtask

    initial begin
        int n;
        logic [3:0] held;

        // Watchdog bound for the whole run.
        fork
            begin
                #2000000;
                $display("FAIL watchdog: run did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
                $fatal(1, "watchdog expired");
            end
        join_none

        sd_run = 1'b1;
        repeat (5) @(negedge clock);
        check("rst_dat", sd_data_out, 4'hF);
        check("rst_oe", sd_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rbs", read_byte_strobe, 0);
        check("rst_wa", write_all_strobe, 0);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);

        // Four zero bytes.
        for (int i = 0; i < 4; i++) data_mem[i] = 8'h00;
        start_xfer(9'd4, 1'b0);
        verify_full("zeros4", 4);

        // Single byte A5.
        data_mem[0] = 8'hA5;
        start_xfer(9'd1, 1'b0);
        verify_full("a5", 1);
        check("a5_hi_nibble", obs_q[obs_base+2], 4'hA);
        check("a5_lo_nibble", obs_q[obs_base+3], 4'h5);

        // Random lengths and contents.
        for (int t = 0; t < 3; t++) begin
            n = $urandom_range(2, 40);
            for (int i = 0; i < n; i++) data_mem[i] = 8'($urandom);
            start_xfer(9'(n), 1'b0);
            verify_full("rand", n);
        end

        // Full 512-byte block via data_count 0, incrementing data.
        for (int i = 0; i < 512; i++) data_mem[i] = 8'(i);
        start_xfer(9'd0, 1'b0);
        verify_full("n512", 512);

        // Abort after ten data nibbles.
        n = $urandom_range(8, 30);
        for (int i = 0; i < n; i++) data_mem[i] = 8'($urandom);
        build_expected(n);
        start_xfer(9'(n), 1'b0);
        wait_obs("abort", 12);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        while (exp_q.size() > 12) void'(exp_q.pop_back());
        exp_q.push_back(4'hF);
        wait_idle("abort", 20000);
        check_seq("abort", 13);
        check("abort_no_done", wa_cnt - wa_base, 0);
        check("abort_busy", busy, 0);
        check("abort_oe", sd_data_oe, 0);

        // Abort while idle has no effect.
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        repeat (40) @(negedge clock);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_oe", sd_data_oe, 0);

        // Reset in the middle of the CRC phase, then a normal 2-byte block.
        data_mem[0] = 8'($urandom);
        start_xfer(9'd1, 1'b0);
        wait_obs("midcrc", 9);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midcrc_oe", sd_data_oe, 0);
        check("midcrc_dat", sd_data_out, 4'hF);
        check("midcrc_busy", busy, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        data_mem[0] = 8'($urandom);
        data_mem[1] = 8'($urandom);
        start_xfer(9'd2, 1'b0);
        verify_full("after_rst", 2);

        // A second write_strobe during DATA is ignored.
        for (int i = 0; i < 3; i++) data_mem[i] = 8'($urandom);
        start_xfer(9'd3, 1'b0);
        wait_obs("ws_busy", 4);
        @(negedge clock);
        write_strobe = 1'b1;
        data_count   = 9'd7;
        @(negedge clock);
        write_strobe = 1'b0;
        verify_full("ws_busy", 3);

        // write_strobe and abort together in IDLE: transfer runs to completion.
        for (int i = 0; i < 5; i++) data_mem[i] = 8'($urandom);
        start_xfer(9'd5, 1'b1);
        verify_full("ws_abort", 5);

        // Stopped sd_clock freezes the bus.
        for (int i = 0; i < 6; i++) data_mem[i] = 8'($urandom);
        start_xfer(9'd6, 1'b0);
        wait_obs("freeze", 5);
        @(negedge clock);
        sd_run = 1'b0;
        repeat (20) @(negedge clock);
        held = sd_data_out;
        repeat (300) @(negedge clock);
        check("freeze_dat", sd_data_out, held);
        check("freeze_oe", sd_data_oe, 1);
        check("freeze_busy", busy, 1);
        sd_run = 1'b1;
        verify_full("freeze", 6);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/sd_write_stream_dat.md
# sd_write_stream_dat

Card-to-host data-line transmitter for the SDIO slave: serialises a block of bytes onto the 4-bit SD DAT bus for CMD53 reads. Each transfer is framed as start nibble, data nibbles, a per-line CRC16 and an end nibble. It is the transmit counterpart of the DAT-line receive stream. It runs in the system `clock` domain, oversamples `sd_clock`, and fetches bytes from an upstream buffer through a fixed-latency request strobe.

## Interface
Parameters:
- BYTE_LATENCY, 2, `clock` cycles from `read_byte_strobe` to `byte_in` valid; legal range 1..3.

Ports:
- clock  in  1  system clock; must be at least 8x `sd_clock`.
- reset_n  in  1  asynchronous, active-low reset.
- sd_clock  in  1  raw SD clock; synchronised internally with two flops.
- write_strobe  in  1  one-cycle pulse that starts a transfer; ignored while `busy`.
- data_count  in  9  byte count latched on `write_strobe`; 0 means 512.
- byte_in  in  8  next byte, sampled BYTE_LATENCY cycles after `read_byte_strobe`.
- abort  in  1  one-cycle pulse that terminates an active transfer (CMD12/IO_ABORT).
- read_byte_strobe  out  1  one-cycle request for the next byte.
- sd_data_out  out  4  DAT[3:0] drive value.
- sd_data_oe  out  1  DAT output enable.
- busy  out  1  high from the `write_strobe` cycle until the return to IDLE.
- write_all_strobe  out  1  one-cycle pulse on normal completion.

## Operation
- Edge detection: `sd_clock` passes through two sync flops. A falling edge is the condition `sync3==1 && sync2==0`. All DAT updates happen only on a detected falling edge, so the host samples on the following rising edge.
- States: IDLE, PREDRIVE, START, DATA, CRC, END, RELEASE.
  - IDLE: `write_strobe` latches `data_count` into an 10-bit nibble counter as 2*N (N=512 when `data_count` is 0), clears the four CRCs and sets `busy`. Goes to PREDRIVE.
  - PREDRIVE: at the next falling edge, `oe`=1 and `sd_data_out`=4'hF. Pulse `read_byte_strobe` once. Goes to START.
  - START: at the next falling edge, drive 4'h0. Goes to DATA.
  - DATA: each falling edge drives one nibble, high nibble first, then low nibble, from the byte buffer. Decrement the nibble counter. After a high nibble is driven and more bytes remain, pulse `read_byte_strobe`. After the last nibble, go to CRC with `crc_idx`=15.
  - CRC: each falling edge drives bit `crc_idx` of CRC line k onto DAT[k], MSB first. Decrement `crc_idx`. After index 0, go to END.
  - END: at the next falling edge, drive 4'hF. Goes to RELEASE.
  - RELEASE: at the next falling edge, `oe`=0. Pulse `write_all_strobe`, clear `busy` and go to IDLE.
- CRC: four existing `sd_crc16` instances, one per line. Polynomial x^16+x^12+x^5+1, init 0.
  - CRC is enabled for one `clock` cycle per data nibble, with bit k of that nibble fed to instance k.
  - Start, CRC and end nibbles are not hashed.
- Byte buffer: an 8-bit register loaded from `byte_in` exactly BYTE_LATENCY cycles after each request. Because of the clock ratio, the byte always lands before the next falling edge.
- `abort`: from any non-IDLE state, go to END at the next falling edge. END then drives 4'hF, and RELEASE drops `oe`.
  - No `write_all_strobe` is issued on an abort.
  - `abort` in IDLE is ignored.
- Simultaneous `write_strobe` and `abort` in IDLE: start the transfer; the abort is ignored.

## Timing
- Reset values: `sd_data_out`=4'hF, `sd_data_oe`=0, `busy`=0, `read_byte_strobe`=0, `write_all_strobe`=0, state IDLE.
- Asserting `reset_n` mid-transfer releases DAT immediately, with no end nibble.
- Bus length: from first `oe` assertion to release, 2N+19 sd_clock falling edges: 1 predrive, 1 start, 2N data, 16 CRC, 1 end.
- Edge latency: outputs change 3 `clock` cycles after a falling `sd_clock` edge at the pin (2 sync flops plus 1 register).
- `write_all_strobe` coincides with the cycle in which `oe` falls.
- `read_byte_strobe` count per transfer equals N exactly. No request is made after the final byte.
- `sd_clock` stopped: all state freezes, and DAT holds its value indefinitely.
- `write_strobe` while `busy`: no effect on any counter or output.

## Test plan
- `data_count`=4, bytes 00,00,00,00 → DAT sequence F,0, eight 0s, sixteen 0s, F, then `oe`=0; 4 requests; one `write_all_strobe`.
- `data_count`=1, byte A5 → nibbles A then 5 after the start nibble. CRC equals the reference model (per line: line3 1,0; line2 0,1; line1 1,0; line0 0,1). Total 21 falling edges with `oe`=1.
- `data_count`=0 with incrementing data, looped back into the DAT receiver (same counts) → 512 bytes received in order, receiver `crc_ok`=1, 1024 data nibbles.
- `abort` during DATA after 10 nibbles → next edge F, following edge `oe`=0; `write_all_strobe` never pulses; `busy` drops.
- `reset_n` low mid-CRC → `oe`=0 and DAT=F asynchronously. After release, a new `write_strobe` with `data_count`=2 completes normally.
- Second `write_strobe` issued during DATA with `data_count`=7 → ignored; transfer length stays at the original N.
